// File: rtl/data_mem_ctrl.sv
// Data-memory controller: single-word writes and LINE_WORDS-word line fills behind a fixed wait latency.
// Optional byte-lane write masking is enabled by defining DMEM_BYTE_MASK_EN.
module data_mem_ctrl #(
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       rd_req,
    input  logic                       wr_req,
    input  logic [9:0]                 addr,
    input  logic [31:0]                wr_data,
`ifdef DMEM_BYTE_MASK_EN
    input  logic [3:0]                 byte_en,
`endif
    output logic [32*LINE_WORDS-1:0]   rd_line,
    output logic                       ready,
    output logic                       busy
);

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic              accept_c;
    logic [CNT_W-1:0]  wait_cnt;
    logic [BEAT_W-1:0] beat;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [BYTES-1:0]  wr_be_c;
    logic [ADDR_W-1:0] rd_addr_c;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

`ifdef DMEM_BYTE_MASK_EN
    logic [BYTES-1:0]  be_q;
    assign wr_be_c = be_q;
`else
    assign wr_be_c = '1;
`endif

    // Burst walks the line upward from its aligned base.
    assign rd_addr_c = {addr_q[ADDR_W-1:BEAT_W], beat};

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_req || rd_req) begin
                    accept_c   = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    next_state = op_wr ? S_WRITE : S_BURST;
                end
            end
            S_BURST: begin
                if (beat == BEAT_W'(LINE_WORDS - 1)) begin
                    next_state = S_DONE;
                end
            end
            S_WRITE: next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            ready <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            ready <= (next_state == S_DONE);
            busy  <= (next_state != S_IDLE);
        end
    end

    // Request capture, wait countdown and line assembly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            beat     <= '0;
            op_wr    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_line  <= '0;
`ifdef DMEM_BYTE_MASK_EN
            be_q     <= '0;
`endif
        end else begin
            if (accept_c) begin
                op_wr    <= wr_req;
                addr_q   <= addr;
                data_q   <= wr_data;
                wait_cnt <= CNT_W'(LATENCY - 1);
                beat     <= '0;
`ifdef DMEM_BYTE_MASK_EN
                be_q     <= byte_en;
`endif
            end else if (state == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (state == S_BURST) begin
                rd_line[DATA_W*int'(beat) +: DATA_W] <= mem[MEM_AW'(rd_addr_c)];
                beat <= beat + BEAT_W'(1);
            end
        end
    end

    // Backing store is never reset; a reset before WRITE leaves it untouched.
    always_ff @(posedge clk) begin
        if (state == S_WRITE) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be_c[i]) begin
                    mem[MEM_AW'(addr_q)][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: transaction-level reference model plus directed and random traffic.
module tb_data_mem_ctrl;

    localparam int unsigned L      = 3;
    localparam int unsigned LW     = 4;
    localparam int unsigned LINE_W = 32 * LW;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              rd_req = 1'b0;
    logic              wr_req = 1'b0;
    logic [9:0]        addr = '0;
    logic [31:0]       wr_data = '0;
`ifdef DMEM_BYTE_MASK_EN
    logic [3:0]        byte_en = 4'hF;
`endif
    logic [LINE_W-1:0] rd_line;
    logic              ready;
    logic              busy;

    data_mem_ctrl #(.MEM_DEPTH(1024), .LINE_WORDS(LW), .LATENCY(L)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .addr    (addr),
        .wr_data (wr_data),
`ifdef DMEM_BYTE_MASK_EN
        .byte_en (byte_en),
`endif
        .rd_line (rd_line),
        .ready   (ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference model: cycles elapsed since accept, and the transaction's total length.
    int                errors = 0;
    int                checks = 0;
    int                phase = 0;
    int                total = 0;
    bit                m_rd = 1'b0;
    logic [9:0]        m_addr = '0;
    logic [31:0]       m_data = '0;
    logic [3:0]        m_be = 4'hF;
    logic [31:0]       mem_m [1024];
    logic [LINE_W-1:0] exp_line = '0;
    logic              prev_ready = 1'b0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    task automatic model_edge();
        logic [9:0] base;
        if (!reset_n) begin
            phase    = 0;
            exp_line = '0;
            return;
        end
        if (phase == 0) begin
            if (wr_req || rd_req) begin
                m_rd   = !wr_req;
                m_addr = addr;
                m_data = wr_data;
`ifdef DMEM_BYTE_MASK_EN
                m_be   = byte_en;
`else
                m_be   = 4'hF;
`endif
                total  = m_rd ? int'(L + LW + 1) : int'(L + 2);
                phase  = 1;
            end
        end else if (phase == total) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == total) begin
                if (m_rd) begin
                    base = {m_addr[9:2], 2'b00};
                    for (int i = 0; i < int'(LW); i++) exp_line[32*i +: 32] = mem_m[base + 10'(i)];
                end else begin
                    mem_m[m_addr] = merge(mem_m[m_addr], m_data, m_be);
                end
            end
        end
    endtask

    task automatic compare();
        check("ready", LINE_W'(ready), LINE_W'(phase != 0 && phase == total));
        check("busy", LINE_W'(busy), LINE_W'(phase != 0));
        check("ready_back_to_back", LINE_W'(prev_ready && ready), '0);
        if (phase == 0 || !m_rd || phase <= int'(L) || phase == total)
            check("rd_line", rd_line, exp_line);
        prev_ready = ready;
    endtask

    task automatic step(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        rd_req  = r;
        wr_req  = w;
        addr    = a;
        wr_data = d;
`ifdef DMEM_BYTE_MASK_EN
        byte_en = be;
`endif
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_until_free();
        for (int n = 0; n < 40 && phase != 0; n++) step(1'b0, 1'b0, '0, '0, 4'hF);
    endtask

    // One transaction from an idle start; returns accept-to-ready cycles and busy cycles before ready.
    task automatic run_txn(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int lat, output int bcyc);
        idle_until_free();
        step(r, w, a, d, be);
        lat  = 1;
        bcyc = 0;
        for (int n = 0; n < 40 && !ready; n++) begin
            if (busy) bcyc++;
            step(1'b0, 1'b0, '0, '0, 4'hF);
            lat++;
        end
        if (!ready) check("ready_timeout", LINE_W'(ready), LINE_W'(1));
    endtask

    initial begin
        int lat;
        int bcyc;
        int cnt;
        int last_rdy;
        int gap_bad;
        logic [LINE_W-1:0] saved;

        for (int i = 0; i < 1024; i++) mem_m[i] = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", LINE_W'(ready), '0);
        check("reset_busy", LINE_W'(busy), '0);
        check("reset_rd_line", rd_line, '0);
        reset_n = 1'b1;
        @(negedge clk);
        compare();

        // Give every word the tests touch a known value.
        for (int a = 0; a < 128; a++) run_txn(1'b0, 1'b1, 10'(a), $urandom, 4'hF, lat, bcyc);

        // Write then read back one word.
        run_txn(1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, lat, bcyc);
        check("wr_latency", LINE_W'(lat), LINE_W'(5));
        check("wr_busy_cycles", LINE_W'(bcyc), LINE_W'(4));
        run_txn(1'b1, 1'b0, 10'h010, '0, 4'hF, lat, bcyc);
        check("rd_word0", LINE_W'(rd_line[31:0]), LINE_W'(32'hDEADBEEF));

        // Line fill from an unaligned address.
        for (int i = 0; i < 4; i++) run_txn(1'b0, 1'b1, 10'(32 + i), 32'(i + 1), 4'hF, lat, bcyc);
        run_txn(1'b1, 1'b0, 10'h022, '0, 4'hF, lat, bcyc);
        check("rd_latency", LINE_W'(lat), LINE_W'(8));
        check("rd_line_0x020", rd_line, 128'h00000004_00000003_00000002_00000001);
        saved = rd_line;

        // Simultaneous read and write: write wins, single ready, line untouched.
        run_txn(1'b1, 1'b1, 10'h030, 32'hCAFEF00D, 4'hF, lat, bcyc);
        check("both_latency", LINE_W'(lat), LINE_W'(5));
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            step(1'b0, 1'b0, '0, '0, 4'hF);
            if (ready) cnt++;
        end
        check("both_extra_ready", LINE_W'(cnt), '0);
        check("both_line_kept", rd_line, saved);
        run_txn(1'b1, 1'b0, 10'h030, '0, 4'hF, lat, bcyc);
        check("both_word0", LINE_W'(rd_line[31:0]), LINE_W'(32'hCAFEF00D));

        // Reset during WAIT of a write aborts it.
        run_txn(1'b0, 1'b1, 10'h040, 32'h11111111, 4'hF, lat, bcyc);
        idle_until_free();
        step(1'b0, 1'b1, 10'h040, 32'h22222222, 4'hF);
        step(1'b0, 1'b0, '0, '0, 4'hF);
        step(1'b0, 1'b0, '0, '0, 4'hF);
        reset_n = 1'b0;
        #1;
        check("rst_busy", LINE_W'(busy), '0);
        check("rst_ready", LINE_W'(ready), '0);
        check("rst_rd_line", rd_line, '0);
        phase    = 0;
        exp_line = '0;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            step(1'b0, 1'b0, '0, '0, 4'hF);
            if (ready) cnt++;
        end
        check("rst_no_ready", LINE_W'(cnt), '0);
        reset_n = 1'b1;
        step(1'b0, 1'b0, '0, '0, 4'hF);
        run_txn(1'b1, 1'b0, 10'h040, '0, 4'hF, lat, bcyc);
        check("rst_mem_kept", LINE_W'(rd_line[31:0]), LINE_W'(32'h11111111));

`ifdef DMEM_BYTE_MASK_EN
        run_txn(1'b0, 1'b1, 10'h050, 32'hAABBCCDD, 4'hF, lat, bcyc);
        run_txn(1'b0, 1'b1, 10'h050, 32'h11223344, 4'b0101, lat, bcyc);
        run_txn(1'b1, 1'b0, 10'h050, '0, 4'hF, lat, bcyc);
        check("byte_mask", LINE_W'(rd_line[31:0]), LINE_W'(32'hAA22CC44));
`endif

        // rd_req held continuously: ready pulses spaced by the read length plus one IDLE cycle.
        idle_until_free();
        cnt = 0;
        last_rdy = -1;
        gap_bad = 0;
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 1'b0, 10'h044, '0, 4'hF);
            if (ready) begin
                if (last_rdy >= 0 && n - last_rdy != int'(L + LW + 2)) gap_bad++;
                last_rdy = n;
                cnt++;
            end
        end
        check("held_rd_gap", LINE_W'(gap_bad), '0);
        check("held_rd_count", LINE_W'(cnt >= 4), LINE_W'(1));

        // Random traffic: requests arrive at any time and are ignored while busy.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 3) == 0, ($urandom % 4) == 0, 10'($urandom_range(0, 127)),
                 $urandom, 4'($urandom));
        end
        idle_until_free();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
